// File: rtl/bus_pkg.sv
// Shared peripheral-bus types and address-map defaults.
package bus_pkg;

   localparam int unsigned DATA_W         = 32;
   localparam int unsigned ADDR_W         = 32;
   localparam logic [31:0] DEF_BASE_ADDR  = 32'h1000_0000;
   localparam int unsigned DEF_SLOT_SHIFT = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } bus_state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } apb_req_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Peripheral-region decoder: byte address to region hit and slot index.
module apb_addr_decode
   import bus_pkg::*;
#(
   parameter int unsigned N_SLOTS    = 4,
   parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
   parameter int unsigned SLOT_SHIFT = DEF_SLOT_SHIFT
) (
   input  logic [ADDR_W-1:0]          addr,
   output logic                       hit_c,
   output logic [$clog2(N_SLOTS)-1:0] slot_c
);

   localparam int unsigned IB = $clog2(N_SLOTS);

   logic unused_addr_lsbs;

   assign hit_c  = (addr[ADDR_W-1:SLOT_SHIFT+IB] == BASE_ADDR[ADDR_W-1:SLOT_SHIFT+IB]);
   assign slot_c = addr[SLOT_SHIFT+IB-1:SLOT_SHIFT];

   assign unused_addr_lsbs = ^addr[SLOT_SHIFT-1:0];

endmodule

// File: rtl/apb_periph_bridge.sv
// Core data-bus to APB bridge: decodes a slot, runs SETUP/ACCESS, returns
// read data with ready/err; decode misses and pready timeouts end in error.
module apb_periph_bridge
   import bus_pkg::*;
#(
   parameter int unsigned N_SLOTS    = 4,
   parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
   parameter int unsigned SLOT_SHIFT = DEF_SLOT_SHIFT,
   parameter int unsigned PADDR_W    = 2,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         rdata,
   output logic                      ready,
   output logic                      err,
   output logic [N_SLOTS-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [PADDR_W-1:0]        paddr,
   output logic [DATA_W-1:0]         pwdata,
   input  logic [N_SLOTS*DATA_W-1:0] prdata,
   input  logic [N_SLOTS-1:0]        pready
);

   localparam int unsigned IB      = $clog2(N_SLOTS);
   localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   bus_state_e          state_q, state_d;
   apb_req_t            xfer_q, xfer_d;
   logic [IB-1:0]       slot_q, slot_d;
   logic [N_SLOTS-1:0]  psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                hit_c;
   logic [IB-1:0]       slot_c;
   logic [DATA_W-1:0]   prdata_s [N_SLOTS];
   logic                unused_xfer_addr;

   apb_addr_decode #(
      .N_SLOTS   (N_SLOTS),
      .BASE_ADDR (BASE_ADDR),
      .SLOT_SHIFT(SLOT_SHIFT)
   ) u_decode (
      .addr  (addr),
      .hit_c (hit_c),
      .slot_c(slot_c)
   );

   for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
      assign prdata_s[i] = prdata[DATA_W*i +: DATA_W];
   end

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      xfer_d    = xfer_q;
      slot_d    = slot_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      rdata_d   = rdata_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      cnt_d     = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (hit_c) begin
                  xfer_d  = '{we: we, addr: addr, wdata: wdata};
                  slot_d  = slot_c;
                  psel_d  = N_SLOTS'(1) << slot_c;
                  state_d = ST_SETUP;
               end else begin
                  rdata_d = '0;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready[slot_q]) begin
               rdata_d   = xfer_q.we ? '0 : prdata_s[slot_q];
               psel_d    = '0;
               penable_d = 1'b0;
               ready_d   = 1'b1;
               state_d   = ST_RESP;
            end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TO_LAST))) begin
               rdata_d   = '0;
               psel_d    = '0;
               penable_d = 1'b0;
               ready_d   = 1'b1;
               err_d     = 1'b1;
               state_d   = ST_RESP;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and latch registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         xfer_q    <= '0;
         slot_q    <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         xfer_q    <= xfer_d;
         slot_q    <= slot_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign psel    = psel_q;
   assign penable = penable_q;
   assign pwrite  = xfer_q.we;
   assign paddr   = xfer_q.addr[PADDR_W+1:2];
   assign pwdata  = xfer_q.wdata;
   assign rdata   = rdata_q;
   assign ready   = ready_q;
   assign err     = err_q;

   assign unused_xfer_addr = ^{xfer_q.addr[ADDR_W-1:PADDR_W+2], xfer_q.addr[1:0]};

endmodule

// File: tb/tb_apb_periph_bridge.sv
// Directed bench for apb_periph_bridge with hand-computed expectations.
module tb_apb_periph_bridge;

   logic         clk;
   logic         reset;
   logic         req;
   logic         we;
   logic [31:0]  addr;
   logic [31:0]  wdata;
   logic [31:0]  rdata;
   logic         ready;
   logic         err;
   logic [3:0]   psel;
   logic         penable;
   logic         pwrite;
   logic [1:0]   paddr;
   logic [31:0]  pwdata;
   logic [127:0] prdata;
   logic [3:0]   pready;

   int n_checks;
   int n_fail;

   apb_periph_bridge dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .ready  (ready),
      .err    (err),
      .psel   (psel),
      .penable(penable),
      .pwrite (pwrite),
      .paddr  (paddr),
      .pwdata (pwdata),
      .prdata (prdata),
      .pready (pready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic saw_ready;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      req      = 1'b0;
      we       = 1'b0;
      addr     = '0;
      wdata    = '0;
      pready   = 4'b1111;
      prdata   = {32'h3333_0003, 32'h1234_5678, 32'hB1B1_0002, 32'hA0A0_0001};
      steps(2);
      check_eq("rst_psel", 64'(psel), 64'h0);
      check_eq("rst_ctl", 64'({penable, pwrite, ready, err}), 64'h0);
      check_eq("rst_paddr", 64'(paddr), 64'h0);
      check_eq("rst_pwdata", 64'(pwdata), 64'h0);
      check_eq("rst_rdata", 64'(rdata), 64'h0);
      reset = 1'b0;
      step();

      // 1: zero-wait write to slot 0
      req = 1'b1; we = 1'b1; addr = 32'h1000_0000; wdata = 32'h0000_000A;
      step();
      check_eq("t1_c1_psel", 64'(psel), 64'h1);
      check_eq("t1_c1_pen", 64'(penable), 64'h0);
      check_eq("t1_c1_pwrite", 64'(pwrite), 64'h1);
      check_eq("t1_c1_paddr", 64'(paddr), 64'h0);
      check_eq("t1_c1_pwdata", 64'(pwdata), 64'hA);
      step();
      check_eq("t1_c2_pen", 64'(penable), 64'h1);
      check_eq("t1_c2_psel", 64'(psel), 64'h1);
      check_eq("t1_c2_ready", 64'(ready), 64'h0);
      step();
      check_eq("t1_c3_ready_err", 64'({ready, err}), 64'b10);
      check_eq("t1_c3_rdata", 64'(rdata), 64'h0);
      check_eq("t1_c3_psel_pen", 64'({psel, penable}), 64'h0);
      req = 1'b0;
      step();
      check_eq("t1_c4_ready", 64'(ready), 64'h0);

      // 2: read slot 2 with three wait cycles; input changes ignored
      pready = 4'b1011;
      req = 1'b1; we = 1'b0; addr = 32'h1000_2004; wdata = 32'hFFFF_FFFF;
      step();
      check_eq("t2_c1_psel", 64'(psel), 64'h4);
      check_eq("t2_c1_paddr", 64'(paddr), 64'h1);
      check_eq("t2_c1_pwrite", 64'(pwrite), 64'h0);
      addr = 32'h1000_300C; we = 1'b1;
      step();
      check_eq("t2_c2_pen", 64'(penable), 64'h1);
      step();
      check_eq("t2_c3_paddr_hold", 64'(paddr), 64'h1);
      check_eq("t2_c3_psel_hold", 64'(psel), 64'h4);
      step();
      check_eq("t2_c4_ready", 64'(ready), 64'h0);
      step();
      check_eq("t2_c5_ready", 64'(ready), 64'h0);
      pready = 4'b1111;
      step();
      check_eq("t2_c6_ready_err", 64'({ready, err}), 64'b10);
      check_eq("t2_c6_rdata", 64'(rdata), 64'h1234_5678);
      req = 1'b0;
      step();

      // 3: decode miss
      req = 1'b1; we = 1'b0; addr = 32'h2000_0000;
      step();
      check_eq("t3_c1_ready_err", 64'({ready, err}), 64'b11);
      check_eq("t3_c1_rdata", 64'(rdata), 64'h0);
      check_eq("t3_c1_psel", 64'(psel), 64'h0);
      req = 1'b0;
      step();
      check_eq("t3_c2_ready", 64'(ready), 64'h0);

      // 4: slot 1 pready stuck low -> timeout after 16 ACCESS cycles
      pready = 4'b1101;
      req = 1'b1; we = 1'b0; addr = 32'h1000_1000;
      step();
      check_eq("t4_c1_psel", 64'(psel), 64'h2);
      saw_ready = 1'b0;
      for (int c = 2; c <= 17; c++) begin
         step();
         saw_ready |= ready;
      end
      check_eq("t4_c17_psel_pen", 64'({psel, penable}), 64'b00101);
      check_eq("t4_no_early_ready", 64'(saw_ready), 64'h0);
      step();
      check_eq("t4_c18_ready_err", 64'({ready, err}), 64'b11);
      check_eq("t4_c18_rdata", 64'(rdata), 64'h0);
      check_eq("t4_c18_psel_pen", 64'({psel, penable}), 64'h0);
      req = 1'b0;
      pready = 4'b1111;
      step();

      // 5: async reset during ACCESS of a slot-3 write
      pready = 4'b0111;
      req = 1'b1; we = 1'b1; addr = 32'h1000_3008; wdata = 32'h0000_DEAD;
      steps(2);
      check_eq("t5_access_pen", 64'({psel, penable}), 64'b10001);
      #1 reset = 1'b1;
      #1;
      check_eq("t5_rst_psel_pen", 64'({psel, penable}), 64'h0);
      check_eq("t5_rst_ready", 64'(ready), 64'h0);
      req = 1'b0;
      #2 reset = 1'b0;
      saw_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         saw_ready |= ready;
      end
      check_eq("t5_no_ready", 64'(saw_ready), 64'h0);
      pready = 4'b1111;
      req = 1'b1; we = 1'b1; addr = 32'h1000_0004; wdata = 32'h0000_0055;
      step();
      check_eq("t5_next_psel", 64'(psel), 64'h1);
      check_eq("t5_next_paddr", 64'(paddr), 64'h1);
      steps(2);
      check_eq("t5_next_ready_err", 64'({ready, err}), 64'b10);
      req = 1'b0;
      step();

      // 6: req held across back-to-back reads of slots 0 and 1
      req = 1'b1; we = 1'b0; addr = 32'h1000_0000;
      step();
      check_eq("t6_c1_psel", 64'(psel), 64'h1);
      steps(2);
      check_eq("t6_c3_ready", 64'({ready, err}), 64'b10);
      check_eq("t6_c3_rdata", 64'(rdata), 64'hA0A0_0001);
      addr = 32'h1000_1000;
      step();
      check_eq("t6_c4_psel", 64'(psel), 64'h0);
      check_eq("t6_c4_ready", 64'(ready), 64'h0);
      step();
      check_eq("t6_c5_psel", 64'(psel), 64'h2);
      steps(2);
      check_eq("t6_c7_ready", 64'({ready, err}), 64'b10);
      check_eq("t6_c7_rdata", 64'(rdata), 64'hB1B1_0002);
      req = 1'b0;
      step();
      check_eq("t6_c8_ready", 64'(ready), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
